// File: rtl/fifo_rd_unpacker_pkg.sv
// fifo_rd_unpacker_pkg
//   Shared types and defaults for the read-side FIFO unpacker.
//   - rd_state_t      : unpacker FSM states (no word held / word held)
//   - FIFO_DATA_WIDTH : default FIFO word width
//   - FIFO_OUT_WIDTH  : default output beat width
//   - beat_width()    : width of the beat counter for a given lane count
package fifo_rd_unpacker_pkg;

  localparam int FIFO_DATA_WIDTH = 64;
  localparam int FIFO_OUT_WIDTH  = 16;

  typedef enum logic [0:0] {
    RD_EMPTY = 1'b0,
    RD_BUSY  = 1'b1
  } rd_state_t;

  // A single-lane word still needs a one-bit counter so the port stays legal.
  function automatic int beat_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_unpacker_if.sv
// fifo_rd_unpacker_if
//   Bundles the FIFO read port and the narrow valid/ready output stream.
//   FIFO side : fifo_rempty, fifo_rdata (head word), fifo_rinc (pop strobe)
//   Stream    : m_valid, m_ready, m_data, m_last
//   master : the unpacker (drives fifo_rinc and the stream outputs)
//   slave  : the environment (FIFO plus downstream consumer)
interface fifo_rd_unpacker_if
  import fifo_rd_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int OUT_WIDTH  = FIFO_OUT_WIDTH
);

  logic                  fifo_rempty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rinc;
  logic                  m_valid;
  logic                  m_ready;
  logic [OUT_WIDTH-1:0]  m_data;
  logic                  m_last;

  modport master (
    input  fifo_rempty, fifo_rdata, m_ready,
    output fifo_rinc, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_rempty, fifo_rdata, m_ready,
    input  fifo_rinc, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker
//   Pops DATA_WIDTH words from the async FIFO read port (rclk domain) and
//   serialises each into DATA_WIDTH/OUT_WIDTH beats, lowest lane first, on a
//   valid/ready stream. A new word is popped on the same edge the last beat of
//   the previous one is accepted, so consecutive words stream without a bubble.
// Ports
//   rclk   : read clock
//   rrst_n : asynchronous active-low reset
//   flush  : synchronous; drops the held word and returns to empty
//   bus    : fifo_rd_unpacker_if.master (FIFO read port + output stream)
module fifo_rd_unpacker
  import fifo_rd_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int OUT_WIDTH  = FIFO_OUT_WIDTH
) (
  input logic                rclk,
  input logic                rrst_n,
  input logic                flush,
  fifo_rd_unpacker_if.master bus
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int BW    = beat_width(RATIO);

  generate
    if ((DATA_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
      $error("fifo_rd_unpacker: DATA_WIDTH must be a multiple of OUT_WIDTH");
    end
  endgenerate

  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

  rd_state_t             state_r;
  rd_state_t             next_state_s;
  logic                  run_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic [DATA_WIDTH-1:0] next_word_s;
  logic [BW-1:0]         beat_r;
  logic [BW-1:0]         next_beat_s;

  logic                           valid_s;
  logic                           last_beat_s;
  logic                           hs_s;
  logic                           pop_s;
  logic [RATIO-1:0][OUT_WIDTH-1:0] lanes_s;

  // View the held word as an array of output lanes, lane 0 in the LSBs.
  assign lanes_s = word_r;

  // Handshake and pop decode. The pop may fire on the last-beat handshake,
  // which makes fifo_rinc combinationally dependent on m_ready.
  always_comb begin
    valid_s     = (state_r == RD_BUSY);
    last_beat_s = (beat_r == LAST_BEAT);
    hs_s        = valid_s & bus.m_ready;
    pop_s       = run_r & ~flush & ~bus.fifo_rempty &
                  ((state_r == RD_EMPTY) | (hs_s & last_beat_s));
  end

  // Stream outputs come straight from the held word and beat counter, so they
  // only move on an accepted beat or a pop.
  always_comb begin
    bus.fifo_rinc = pop_s;
    bus.m_valid   = valid_s;
    bus.m_last    = valid_s & last_beat_s;
    bus.m_data    = lanes_s[beat_r];
  end

  // Next-state logic: flush wins, then a pop reloads the word, then an
  // accepted beat advances or empties the unpacker.
  always_comb begin
    next_state_s = state_r;
    next_word_s  = word_r;
    next_beat_s  = beat_r;
    if (flush) begin
      next_state_s = RD_EMPTY;
      next_beat_s  = {BW{1'b0}};
    end else if (pop_s) begin
      next_state_s = RD_BUSY;
      next_word_s  = bus.fifo_rdata;
      next_beat_s  = {BW{1'b0}};
    end else begin
      case (state_r)
        RD_BUSY: begin
          if (hs_s && last_beat_s) begin
            next_state_s = RD_EMPTY;
            next_beat_s  = {BW{1'b0}};
          end else if (hs_s) begin
            next_beat_s = beat_r + BEAT_ONE;
          end else begin
            next_beat_s = beat_r;
          end
        end
        RD_EMPTY: begin
          next_state_s = RD_EMPTY;
        end
        default: begin
          next_state_s = RD_EMPTY;
          next_beat_s  = {BW{1'b0}};
        end
      endcase
    end
  end

  // State, word and beat registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r <= RD_EMPTY;
      word_r  <= {DATA_WIDTH{1'b0}};
      beat_r  <= {BW{1'b0}};
    end else begin
      state_r <= next_state_s;
      word_r  <= next_word_s;
      beat_r  <= next_beat_s;
    end
  end

  // Run flag: holds off popping for the first edge after reset release so the
  // FIFO's own reset has settled before we touch it.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

endmodule
